// File: rtl/hdmi_timing_scaler.sv
// HDMI raster timing generator with a centred, integer-scaled GBA image window.
// Produces sync/DE, GBA pixel coordinates and a one-cycle row fetch request per GBA line.
module hdmi_timing_scaler #(
  parameter int   WIDTH_MAX     = 2200,
  parameter int   HEIGHT_MAX    = 1125,
  parameter int   FRAME_WIDTH   = 1920,
  parameter int   FRAME_HEIGHT  = 1080,
  parameter int   H_FRONT       = 88,
  parameter int   H_SYNC        = 44,
  parameter int   V_FRONT       = 4,
  parameter int   V_SYNC        = 5,
  parameter int   MAX_SCALE_CNT = 5,
  parameter int   GBA_W         = 240,
  parameter int   GBA_H         = 160,
  parameter logic SYNC_POL      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resync,
  output logic [11:0] hCnt,
  output logic [10:0] vCnt,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frameStart,
  output logic        gbaActive,
  output logic [7:0]  gbaX,
  output logic [7:0]  gbaY,
  output logic        lineReq,
  output logic [7:0]  lineReqY
);

  localparam int IW   = GBA_W * (MAX_SCALE_CNT + 1);
  localparam int IH   = GBA_H * (MAX_SCALE_CNT + 1);
  localparam int XOFF = (FRAME_WIDTH - IW) / 2;
  localparam int YOFF = (FRAME_HEIGHT - IH) / 2;

  localparam logic [11:0] H_LAST = 12'(WIDTH_MAX - 1);
  localparam logic [11:0] H_ACT  = 12'(FRAME_WIDTH);
  localparam logic [11:0] HS_BEG = 12'(FRAME_WIDTH + H_FRONT);
  localparam logic [11:0] HS_END = 12'(FRAME_WIDTH + H_FRONT + H_SYNC);
  localparam logic [11:0] X_PRE  = 12'(XOFF - 1);
  localparam logic [11:0] X_BEG  = 12'(XOFF);
  localparam logic [11:0] X_END  = 12'(XOFF + IW);
  localparam logic [10:0] V_LAST = 11'(HEIGHT_MAX - 1);
  localparam logic [10:0] V_ACT  = 11'(FRAME_HEIGHT);
  localparam logic [10:0] VS_BEG = 11'(FRAME_HEIGHT + V_FRONT);
  localparam logic [10:0] VS_END = 11'(FRAME_HEIGHT + V_FRONT + V_SYNC);
  localparam logic [10:0] Y_PRE  = 11'(YOFF - 1);
  localparam logic [10:0] Y_BEG  = 11'(YOFF);
  localparam logic [10:0] Y_END  = 11'(YOFF + IH);
  localparam logic [3:0]  SC_MAX = 4'(MAX_SCALE_CNT);
  localparam logic [7:0]  GX_MAX = 8'(GBA_W - 1);
  localparam logic [7:0]  GY_MAX = 8'(GBA_H - 1);

  logic [11:0] h;
  logic [10:0] v;
  logic [3:0]  x_scale, y_scale;
  logic [7:0]  gx, gy;
  logic        pend;

  logic        h_wrap, restart, x_win, y_win, line_req_c, hs_c, vs_c;
  logic [10:0] v_inc, v_next;
  logic [7:0]  line_req_y_c;

  always_comb begin
    h_wrap       = (h == H_LAST);
    restart      = h_wrap && (pend || resync);
    x_win        = (h >= X_BEG) && (h < X_END);
    y_win        = (v >= Y_BEG) && (v < Y_END);
    v_inc        = v + 11'd1;
    v_next       = (v == V_LAST) ? 11'd0 : v_inc;
    hs_c         = (h >= HS_BEG) && (h < HS_END);
    vs_c         = (v >= VS_BEG) && (v < VS_END);
    // Request the row that the next line will start displaying.
    line_req_c   = (h == H_ACT) &&
                   ((v == Y_PRE) || (y_win && (v_inc < Y_END) && (y_scale == SC_MAX)));
    line_req_y_c = (v == Y_PRE) ? 8'd0 : gy + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h       <= '0;
      v       <= '0;
      x_scale <= '0;
      y_scale <= '0;
      gx      <= '0;
      gy      <= '0;
      pend    <= 1'b0;
    end else begin
      h <= h_wrap ? 12'd0 : h + 12'd1;

      if (h_wrap)      pend <= 1'b0;
      else if (resync) pend <= 1'b1;

      if (restart || (h == X_PRE)) begin
        x_scale <= '0;
        gx      <= '0;
      end else if (x_win) begin
        if (x_scale == SC_MAX) begin
          x_scale <= '0;
          if (gx != GX_MAX) gx <= gx + 8'd1;
        end else begin
          x_scale <= x_scale + 4'd1;
        end
      end

      if (h_wrap) begin
        if (restart) begin
          v       <= '0;
          y_scale <= '0;
          gy      <= '0;
        end else begin
          v <= v_next;
          if (v_next == Y_BEG) begin
            y_scale <= '0;
            gy      <= '0;
          end else if (y_win) begin
            if (y_scale == SC_MAX) begin
              y_scale <= '0;
              if (gy != GY_MAX) gy <= gy + 8'd1;
            end else begin
              y_scale <= y_scale + 4'd1;
            end
          end
        end
      end
    end
  end

  // Outputs are a registered image of the current internal position, so all share one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCnt       <= '0;
      vCnt       <= '0;
      de         <= 1'b0;
      hsync      <= !SYNC_POL;
      vsync      <= !SYNC_POL;
      frameStart <= 1'b0;
      gbaActive  <= 1'b0;
      gbaX       <= '0;
      gbaY       <= '0;
      lineReq    <= 1'b0;
      lineReqY   <= '0;
    end else begin
      hCnt       <= h;
      vCnt       <= v;
      de         <= (h < H_ACT) && (v < V_ACT);
      hsync      <= hs_c ? SYNC_POL : !SYNC_POL;
      vsync      <= vs_c ? SYNC_POL : !SYNC_POL;
      frameStart <= (h == 12'd0) && (v == 11'd0);
      gbaActive  <= x_win && y_win;
      gbaX       <= gx;
      gbaY       <= gy;
      lineReq    <= line_req_c;
      lineReqY   <= line_req_c ? line_req_y_c : lineReqY;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_scaler.sv
// Bench for hdmi_timing_scaler: full 1080p instance for reset/line timing, plus a
// miniature raster instance for frame-level mapping, lineReq, resync and mid-frame reset.
module tb_hdmi_timing_scaler;

  localparam int WM = 41, HM = 20, FW = 31, FH = 16, HF = 3, HSW = 4, VF = 1, VSW = 2;
  localparam int SCM = 2, GW = 8, GH = 4;
  localparam int S = SCM + 1, IW = GW * S, IH = GH * S;
  localparam int XOFF = (FW - IW) / 2, YOFF = (FH - IH) / 2;
  localparam int FRAME = WM * HM;

  logic clk = 1'b0, rst_n = 1'b0, resync = 1'b0;

  logic [11:0] f_hCnt, s_hCnt;
  logic [10:0] f_vCnt, s_vCnt;
  logic f_de, f_hsync, f_vsync, f_frameStart, f_gbaActive, f_lineReq;
  logic s_de, s_hsync, s_vsync, s_frameStart, s_gbaActive, s_lineReq;
  logic [7:0] f_gbaX, f_gbaY, f_lineReqY, s_gbaX, s_gbaY, s_lineReqY;

  hdmi_timing_scaler dut_full (
    .clk(clk), .rst_n(rst_n), .resync(resync), .hCnt(f_hCnt), .vCnt(f_vCnt), .de(f_de),
    .hsync(f_hsync), .vsync(f_vsync), .frameStart(f_frameStart), .gbaActive(f_gbaActive),
    .gbaX(f_gbaX), .gbaY(f_gbaY), .lineReq(f_lineReq), .lineReqY(f_lineReqY));

  hdmi_timing_scaler #(
    .WIDTH_MAX(WM), .HEIGHT_MAX(HM), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .H_FRONT(HF),
    .H_SYNC(HSW), .V_FRONT(VF), .V_SYNC(VSW), .MAX_SCALE_CNT(SCM), .GBA_W(GW), .GBA_H(GH),
    .SYNC_POL(1'b1)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .resync(resync), .hCnt(s_hCnt), .vCnt(s_vCnt), .de(s_de),
    .hsync(s_hsync), .vsync(s_vsync), .frameStart(s_frameStart), .gbaActive(s_gbaActive),
    .gbaX(s_gbaX), .gbaY(s_gbaY), .lineReq(s_lineReq), .lineReqY(s_lineReqY));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    int h; int v; int act; int gx; int gy; int lr; int lry;
  } vec_t;
  vec_t vecs[18];

  int snap_act[HM][WM], snap_gx[HM][WM], snap_gy[HM][WM], snap_lr[HM][WM], snap_lry[HM][WM];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input string name, input int h, input int v);
    int k = 0;
    while (!(int'(s_hCnt) == h && (v < 0 || int'(s_vCnt) == v)) && k < 4 * FRAME) begin
      step();
      k++;
    end
    if (k >= 4 * FRAME) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: position h=%0d v=%0d not reached, got h=%0d v=%0d", name, h, v,
               int'(s_hCnt), int'(s_vCnt));
    end
  endtask

  initial begin
    int de_cnt, de_last, hs_cnt, hs_first, hs_last, cnt_err, gba_cnt;
    int eh, ev, fs_last, fs_cnt, lr_cnt, vs_cnt, bad;

    //          h   v  act gx  gy  lr lry
    vecs[0]  = '{2,  2, 0, -1, -1, 0, -1};
    vecs[1]  = '{3,  2, 1,  0,  0, 0, -1};
    vecs[2]  = '{5,  2, 1,  0,  0, 0, -1};
    vecs[3]  = '{6,  2, 1,  1,  0, 0, -1};
    vecs[4]  = '{26, 2, 1,  7,  0, 0, -1};
    vecs[5]  = '{27, 2, 0, -1, -1, 0, -1};
    vecs[6]  = '{3,  4, 1,  0,  0, 0, -1};
    vecs[7]  = '{3,  5, 1,  0,  1, 0, -1};
    vecs[8]  = '{26, 13, 1, 7,  3, 0, -1};
    vecs[9]  = '{3,  14, 0, -1, -1, 0, -1};
    vecs[10] = '{3,  1, 0, -1, -1, 0, -1};
    vecs[11] = '{31, 1, 0, -1, -1, 1, 0};
    vecs[12] = '{31, 4, 0, -1, -1, 1, 1};
    vecs[13] = '{31, 7, 0, -1, -1, 1, 2};
    vecs[14] = '{31, 10, 0, -1, -1, 1, 3};
    vecs[15] = '{31, 13, 0, -1, -1, 0, -1};
    vecs[16] = '{30, 1, 0, -1, -1, 0, -1};
    vecs[17] = '{28, 2, 0, -1, -1, 0, -1};

    // Reset held for 10 cycles
    repeat (10) step();
    check("rst_f_flags", int'({f_de, f_hsync, f_vsync, f_frameStart, f_gbaActive, f_lineReq}), 0);
    check("rst_f_cnt", int'(f_hCnt) + int'(f_vCnt), 0);
    check("rst_f_gba", int'({f_gbaX, f_gbaY, f_lineReqY}), 0);
    check("rst_s_flags", int'({s_de, s_hsync, s_vsync, s_frameStart, s_gbaActive, s_lineReq}), 0);
    check("rst_s_cnt", int'(s_hCnt) + int'(s_vCnt), 0);

    rst_n = 1'b1;
    step();
    check("start_frame_pulse", int'(f_frameStart), 1);
    check("start_hcnt", int'(f_hCnt), 0);
    check("start_vcnt", int'(f_vCnt), 0);
    check("start_small_pulse", int'(s_frameStart), 1);

    // One 1080p line
    de_cnt = 0; de_last = -1; hs_cnt = 0; hs_first = -1; hs_last = -1; cnt_err = 0; gba_cnt = 0;
    for (int i = 0; i < 2200; i++) begin
      if (int'(f_hCnt) != i || f_vCnt != 11'd0) cnt_err++;
      if (f_de) begin de_cnt++; de_last = i; end
      if (f_hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (f_gbaActive || f_lineReq || f_vsync) gba_cnt++;
      step();
    end
    check("line_hcnt_seq", cnt_err, 0);
    check("line_de_count", de_cnt, 1920);
    check("line_de_last", de_last, 1919);
    check("line_hsync_count", hs_cnt, 44);
    check("line_hsync_first", hs_first, 2008);
    check("line_hsync_last", hs_last, 2051);
    check("line0_quiet", gba_cnt, 0);
    check("line_len_hcnt", int'(f_hCnt), 0);
    check("line_len_vcnt", int'(f_vCnt), 1);

    // Two miniature frames against an arithmetic model
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    eh = 0; ev = 0; fs_last = -1; fs_cnt = 0; lr_cnt = 0; vs_cnt = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      int ede, ehs, evs, efs, eact, nl, elr, elry, ok;
      ede  = int'(eh < FW && ev < FH);
      ehs  = int'(eh >= FW + HF && eh < FW + HF + HSW);
      evs  = int'(ev >= FH + VF && ev < FH + VF + VSW);
      efs  = int'(eh == 0 && ev == 0);
      eact = int'(eh >= XOFF && eh < XOFF + IW && ev >= YOFF && ev < YOFF + IH);
      nl   = ev + 1 - YOFF;
      elr  = int'(eh == FW && nl >= 0 && nl < IH && (nl % S) == 0);
      elry = nl / S;
      ok = int'(int'(s_hCnt) == eh && int'(s_vCnt) == ev && int'(s_de) == ede &&
                int'(s_hsync) == ehs && int'(s_vsync) == evs && int'(s_frameStart) == efs &&
                int'(s_gbaActive) == eact && int'(s_lineReq) == elr);
      if (eact != 0 && (int'(s_gbaX) != (eh - XOFF) / S || int'(s_gbaY) != (ev - YOFF) / S)) ok = 0;
      if (elr != 0 && int'(s_lineReqY) != elry) ok = 0;
      n_tests++;
      if (ok == 0) begin
        n_fail++;
        $display("FAIL frame_model h=%0d v=%0d: got h=%0d v=%0d de=%0d hs=%0d vs=%0d fs=%0d act=%0d x=%0d y=%0d lr=%0d ly=%0d",
                 eh, ev, int'(s_hCnt), int'(s_vCnt), s_de, s_hsync, s_vsync, s_frameStart,
                 s_gbaActive, int'(s_gbaX), int'(s_gbaY), s_lineReq, int'(s_lineReqY));
      end
      if (c < FRAME) begin
        snap_act[ev][eh] = int'(s_gbaActive);
        snap_gx[ev][eh]  = int'(s_gbaX);
        snap_gy[ev][eh]  = int'(s_gbaY);
        snap_lr[ev][eh]  = int'(s_lineReq);
        snap_lry[ev][eh] = int'(s_lineReqY);
        if (s_lineReq) lr_cnt++;
      end
      if (s_vsync) vs_cnt++;
      if (s_frameStart) begin
        if (fs_last >= 0) check("frame_interval", c - fs_last, FRAME);
        fs_last = c;
        fs_cnt++;
      end
      eh = (eh == WM - 1) ? 0 : eh + 1;
      if (eh == 0) ev = (ev == HM - 1) ? 0 : ev + 1;
      step();
    end
    check("frame_start_count", fs_cnt, 2);
    check("linereq_per_frame", lr_cnt, GH);
    check("vsync_cycles", vs_cnt, 2 * VSW * WM);

    for (int i = 0; i < 18; i++) begin
      check($sformatf("vec%0d_act", i), snap_act[vecs[i].v][vecs[i].h], vecs[i].act);
      if (vecs[i].gx >= 0) check($sformatf("vec%0d_gbax", i), snap_gx[vecs[i].v][vecs[i].h], vecs[i].gx);
      if (vecs[i].gy >= 0) check($sformatf("vec%0d_gbay", i), snap_gy[vecs[i].v][vecs[i].h], vecs[i].gy);
      check($sformatf("vec%0d_linereq", i), snap_lr[vecs[i].v][vecs[i].h], vecs[i].lr);
      if (vecs[i].lry >= 0) check($sformatf("vec%0d_linereqy", i), snap_lry[vecs[i].v][vecs[i].h], vecs[i].lry);
    end

    // Mid-line resync restarts at the next line boundary
    wait_pos("rs_mid_pos", 10, 8);
    resync = 1'b1; step(); resync = 1'b0;
    wait_pos("rs_mid_wrap", 0, -1);
    check("rs_mid_vcnt", int'(s_vCnt), 0);
    check("rs_mid_fs", int'(s_frameStart), 1);

    // Second resync while pending gives one restart only
    wait_pos("rs_abs_pos", 5, 3);
    resync = 1'b1; step(); resync = 1'b0;
    repeat (3) step();
    resync = 1'b1; step(); resync = 1'b0;
    wait_pos("rs_abs_wrap", 0, -1);
    check("rs_abs_vcnt0", int'(s_vCnt), 0);
    step();
    wait_pos("rs_abs_next", 0, -1);
    check("rs_abs_vcnt1", int'(s_vCnt), 1);

    // Resync on the wrap cycle itself (internal h = WM-1)
    wait_pos("rs_wrap_pos", WM - 2, 4);
    resync = 1'b1; step(); resync = 1'b0;
    check("rs_wrap_pre_v", int'(s_vCnt), 4);
    step();
    check("rs_wrap_vcnt", int'(s_vCnt), 0);
    check("rs_wrap_fs", int'(s_frameStart), 1);

    // Resync coinciding with the natural frame wrap, then flag must be clear
    wait_pos("rs_nat_pos", WM - 2, HM - 1);
    resync = 1'b1; step(); resync = 1'b0;
    step();
    check("rs_nat_fs", int'(s_frameStart), 1);
    repeat (WM) step();
    check("rs_nat_next_v", int'(s_vCnt), 1);
    check("rs_nat_next_h", int'(s_hCnt), 0);

    // Asynchronous reset inside the image window
    wait_pos("mr_pos", 10, 5);
    check("mr_pre_active", int'(s_gbaActive), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_async_flags", int'({s_de, s_hsync, s_vsync, s_gbaActive, s_lineReq, f_de, f_gbaActive}), 0);
    check("mr_async_cnt", int'(s_hCnt) + int'(s_vCnt) + int'(s_gbaX) + int'(s_gbaY), 0);
    bad = 0;
    repeat (5) begin
      step();
      bad += int'(s_lineReq) + int'(s_gbaActive) + int'(f_lineReq) + int'(f_gbaActive);
    end
    check("mr_hold_quiet", bad, 0);

    // Reset dropped the cycle before a lineReq would register
    rst_n = 1'b1;
    wait_pos("mr2_pos", FW - 1, YOFF - 1);
    #2 rst_n = 1'b0;
    bad = 0;
    repeat (3) begin
      step();
      bad += int'(s_lineReq);
    end
    check("mr2_no_linereq", bad, 0);
    rst_n = 1'b1;
    step();
    check("mr2_restart_fs", int'(s_frameStart), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
